// File: rtl/clk_div_pkg.sv
// Shared constants and the per-channel configuration record for the multi-channel clock divider.
package clk_div_pkg;

  localparam int NCH_DEF = 4;
  localparam int W_DEF   = 28;
  localparam int W_MAX   = 32;

  // Fields are sized for the widest legal counter; narrower channels zero-extend
  // into them, so the unused upper bits stay constant and fold away.
  typedef struct packed {
    logic [W_MAX-1:0] period;
    logic [W_MAX-1:0] high;
  } chan_cfg_t;

  function automatic chan_cfg_t make_cfg(input logic [W_MAX-1:0] period,
                                         input logic [W_MAX-1:0] high);
    chan_cfg_t c;
    c.period = period;
    c.high   = high;
    return c;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending configuration, tick and duty-shaped output.
// Optional macro CLK_DIV_SYNC_EN adds a sync input that restarts the channel at cnt=0.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
`ifdef CLK_DIV_SYNC_EN
  input  logic         sync,
`endif
  input  logic [W-1:0] period,
  input  logic [W-1:0] high,
  output logic         tick,
  output logic         out_clk,
  output logic         pend
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_next;
  chan_cfg_t    act_q;
  chan_cfg_t    act_next;
  chan_cfg_t    pnd_q;
  chan_cfg_t    pnd_next;
  chan_cfg_t    load_cfg;
  logic         pend_next;
  logic         wrap;
  logic         bypass;
  logic         apply_pnd;
  logic         sync_hit;
  logic         tick_next;
  logic         out_clk_next;

`ifdef CLK_DIV_SYNC_EN
  assign sync_hit = sync;
`else
  assign sync_hit = 1'b0;
`endif

  // load is a one-cycle strobe with no back-pressure: whatever is on period/high
  // in that cycle is taken, and a later strobe before application replaces it.
  always_comb begin
    load_cfg     = make_cfg(W_MAX'(period), W_MAX'(high));
    act_next     = act_q;
    pnd_next     = pnd_q;
    pend_next    = pend;
    cnt_next     = cnt + W'(1);
    wrap         = en && (W_MAX'(cnt) == act_q.period);
    bypass       = load && wrap && !sync_hit;
    apply_pnd    = pend && (wrap || !en || sync_hit);

    if (bypass) begin
      act_next  = load_cfg;
      pend_next = 1'b0;
    end else begin
      if (apply_pnd) begin
        act_next  = pnd_q;
        pend_next = 1'b0;
      end
      if (load) begin
        pnd_next  = load_cfg;
        pend_next = 1'b1;
      end
    end

    if (!en || sync_hit || wrap) begin
      cnt_next = '0;
    end

    // Duty compare uses the configuration that owns the upcoming cycle, so a new
    // period starts cleanly with its own high time.
    tick_next    = wrap && !sync_hit;
    out_clk_next = en && (W_MAX'(cnt_next) < act_next.high);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      act_q   <= '0;
      pnd_q   <= '0;
      pend    <= 1'b0;
      tick    <= 1'b0;
      out_clk <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      act_q   <= act_next;
      pnd_q   <= pnd_next;
      pend    <= pend_next;
      tick    <= tick_next;
      out_clk <= out_clk_next;
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// NCH independent programmable dividers; this level only slices the buses per channel.
// Optional macro CLK_DIV_SYNC_EN adds a global sync input shared by all channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int W   = W_DEF
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CLK_DIV_SYNC_EN
  input  logic             sync,
`endif
  input  logic [NCH-1:0]   en,
  input  logic [NCH*W-1:0] period,
  input  logic [NCH*W-1:0] high,
  input  logic [NCH-1:0]   load,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   out_clk,
  output logic [NCH-1:0]   pend
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clk_div_chan #(
      .W(W)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en     (en[i]),
      .load   (load[i]),
`ifdef CLK_DIV_SYNC_EN
      .sync   (sync),
`endif
      .period (period[i*W +: W]),
      .high   (high[i*W +: W]),
      .tick   (tick[i]),
      .out_clk(out_clk[i]),
      .pend   (pend[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed table, corner sequences, randomized run
// against a period-level reference model. Covers CLK_DIV_SYNC_EN when that macro is defined.
module tb_clk_div_multi;

  localparam int NCH = 2;
  localparam int W   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   en;
  logic [NCH-1:0]   load;
  logic [NCH*W-1:0] period;
  logic [NCH*W-1:0] high;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   out_clk;
  logic [NCH-1:0]   pend;
`ifdef CLK_DIV_SYNC_EN
  logic             sync;
`endif

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  clk_div_multi #(
    .NCH(NCH),
    .W  (W)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
`ifdef CLK_DIV_SYNC_EN
    .sync   (sync),
`endif
    .en     (en),
    .period (period),
    .high   (high),
    .load   (load),
    .tick   (tick),
    .out_clk(out_clk),
    .pend   (pend)
  );

  // reference model: position inside the current period, the configuration that
  // owns the period, and at most one waiting configuration
  int             m_pos [NCH];
  int             m_p   [NCH];
  int             m_h   [NCH];
  int             m_pp  [NCH];
  int             m_hp  [NCH];
  logic [NCH-1:0] m_has;
  logic [NCH-1:0] m_tick;
  logic [NCH-1:0] m_oc;

  typedef struct {
    logic         en;
    logic         load;
    logic [W-1:0] p;
    logic [W-1:0] h;
    logic         tick;
    logic         oc;
    logic         pend;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pos[i] = 0;
      m_p[i]   = 0;
      m_h[i]   = 0;
      m_pp[i]  = 0;
      m_hp[i]  = 0;
    end
    m_has  = '0;
    m_tick = '0;
    m_oc   = '0;
  endtask

  task automatic model_step();
    bit s;
    int lp;
    int lh;
    bit done;
    s = 1'b0;
`ifdef CLK_DIV_SYNC_EN
    s = sync;
`endif
    for (int i = 0; i < NCH; i++) begin
      lp   = int'(period[i*W +: W]);
      lh   = int'(high[i*W +: W]);
      done = en[i] && (m_pos[i] == m_p[i]);
      m_tick[i] = done && !s;
      if (load[i] && done && !s) begin
        m_p[i] = lp;
        m_h[i] = lh;
        m_has[i] = 1'b0;
      end else begin
        if (m_has[i] && (done || !en[i] || s)) begin
          m_p[i] = m_pp[i];
          m_h[i] = m_hp[i];
          m_has[i] = 1'b0;
        end
        if (load[i]) begin
          m_pp[i] = lp;
          m_hp[i] = lh;
          m_has[i] = 1'b1;
        end
      end
      m_pos[i] = (!en[i] || s || done) ? 0 : m_pos[i] + 1;
      m_oc[i]  = en[i] && (m_pos[i] < m_h[i]);
    end
  endtask

  // driver tasks
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("model_tick", tick, m_tick);
    chk("model_out_clk", out_clk, m_oc);
    chk("model_pend", pend, m_has);
    load = '0;
`ifdef CLK_DIV_SYNC_EN
    sync = 1'b0;
`endif
  endtask

  task automatic set_cfg(input int ch, input int p, input int h);
    period[ch*W +: W] = W'(p);
    high[ch*W +: W]   = W'(h);
    load[ch]          = 1'b1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    en     = '0;
    load   = '0;
    period = '0;
    high   = '0;
`ifdef CLK_DIV_SYNC_EN
    sync   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("reset_tick", tick, 0);
    chk("reset_out_clk", out_clk, 0);
    chk("reset_pend", pend, 0);
    rst = 1'b0;
  endtask

  task automatic run_until_tick(input int ch, input int budget,
                                output int n, output int highs, output int pends);
    n = 0;
    highs = 0;
    pends = 0;
    do begin
      cycle();
      n++;
      if (out_clk[ch]) highs++;
      if (pend[ch]) pends++;
    end while (!tick[ch] && n < budget);
    if (!tick[ch]) chk("tick_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hi, pe, f0, f1;

    // P=3/H=2 loaded while disabled, then enabled (first edge also closes the P=0 period)
    vt[0] = '{en:1'b0, load:1'b1, p:8'd3, h:8'd2, tick:1'b0, oc:1'b0, pend:1'b1};
    vt[1] = '{en:1'b1, load:1'b0, p:8'd0, h:8'd0, tick:1'b1, oc:1'b1, pend:1'b0};
    vt[2] = '{en:1'b1, load:1'b0, p:8'd0, h:8'd0, tick:1'b0, oc:1'b1, pend:1'b0};
    vt[3] = '{en:1'b1, load:1'b0, p:8'd0, h:8'd0, tick:1'b0, oc:1'b0, pend:1'b0};
    vt[4] = '{en:1'b1, load:1'b0, p:8'd0, h:8'd0, tick:1'b0, oc:1'b0, pend:1'b0};
    vt[5] = '{en:1'b1, load:1'b0, p:8'd0, h:8'd0, tick:1'b1, oc:1'b1, pend:1'b0};
    vt[6] = '{en:1'b1, load:1'b0, p:8'd0, h:8'd0, tick:1'b0, oc:1'b1, pend:1'b0};
    vt[7] = '{en:1'b1, load:1'b0, p:8'd0, h:8'd0, tick:1'b0, oc:1'b0, pend:1'b0};
    vt[8] = '{en:1'b1, load:1'b0, p:8'd0, h:8'd0, tick:1'b0, oc:1'b0, pend:1'b0};
    vt[9] = '{en:1'b1, load:1'b0, p:8'd0, h:8'd0, tick:1'b1, oc:1'b1, pend:1'b0};

    do_reset();
    for (int k = 0; k < 10; k++) begin
      en[0] = vt[k].en;
      if (vt[k].load) set_cfg(0, int'(vt[k].p), int'(vt[k].h));
      cycle();
      chk($sformatf("t032_tick[%0d]", k), tick[0], vt[k].tick);
      chk($sformatf("t032_out_clk[%0d]", k), out_clk[0], vt[k].oc);
      chk($sformatf("t032_pend[%0d]", k), pend[0], vt[k].pend);
    end

    // reconfigure mid-period: running 10-cycle period must finish intact
    do_reset();
    en = 2'b01;
    set_cfg(0, 9, 5);
    cycle();
    chk("t033_bypass_tick", tick[0], 1);
    chk("t033_bypass_pend", pend[0], 0);
    cycle();
    cycle();
    set_cfg(0, 4, 1);
    cycle();
    chk("t033_pend_set", pend[0], 1);
    run_until_tick(0, 20, n, hi, pe);
    chk("t033_old_period_rest", n, 7);
    chk("t033_pend_applied", pend[0], 0);
    for (int r = 0; r < 2; r++) begin
      run_until_tick(0, 20, n, hi, pe);
      chk("t033_new_period", n, 5);
      chk("t033_new_high", hi, 1);
    end

    // load on the wrap cycle bypasses the pending pair
    do_reset();
    en = 2'b01;
    set_cfg(0, 3, 2);
    cycle();
    repeat (3) cycle();
    set_cfg(0, 1, 1);
    cycle();
    chk("t034_wrap_tick", tick[0], 1);
    chk("t034_pend_low", pend[0], 0);
    for (int r = 0; r < 2; r++) begin
      run_until_tick(0, 10, n, hi, pe);
      chk("t034_period", n, 2);
      chk("t034_pend_never", pe, 0);
    end

    // P=0 extremes
    do_reset();
    en = 2'b01;
    set_cfg(0, 0, 0);
    repeat (4) begin
      cycle();
      chk("t035_tick_each", tick[0], 1);
      chk("t035_out_low", out_clk[0], 0);
    end
    set_cfg(0, 0, 5);
    repeat (4) begin
      cycle();
      chk("t035_tick_each_h5", tick[0], 1);
      chk("t035_out_high", out_clk[0], 1);
    end

    // asynchronous reset mid-period
    do_reset();
    en = 2'b01;
    set_cfg(0, 9, 8);
    cycle();
    repeat (6) cycle();
    chk("t036_pre_out_high", out_clk[0], 1);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t036_async_tick", tick, 0);
    chk("t036_async_out_clk", out_clk, 0);
    chk("t036_async_pend", pend, 0);
    @(posedge clk);
    #1;
    chk("t036_held_tick", tick, 0);
    chk("t036_held_out_clk", out_clk, 0);
    rst = 1'b0;
    repeat (4) begin
      cycle();
      chk("t036_tick_after", tick[0], 1);
      chk("t036_out_after", out_clk[0], 0);
    end

`ifdef CLK_DIV_SYNC_EN
    // global sync realigns both channels
    do_reset();
    en = 2'b11;
    set_cfg(0, 3, 2);
    set_cfg(1, 5, 3);
    cycle();
    repeat ($urandom_range(3, 12)) cycle();
    sync = 1'b1;
    cycle();
    chk("t037_sync_no_tick", tick, 0);
    f0 = 0;
    f1 = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (tick[0] && f0 == 0) f0 = k;
      if (tick[1] && f1 == 0) f1 = k;
    end
    chk("t037_first_tick_ch0", f0, 4);
    chk("t037_first_tick_ch1", f1, 6);
`endif

    // randomized run against the model
    do_reset();
    en = 2'b11;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 19) == 0) en[i] = ~en[i];
        if ($urandom_range(0, 7) == 0)
          set_cfg(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 9)));
      end
`ifdef CLK_DIV_SYNC_EN
      if ($urandom_range(0, 29) == 0) sync = 1'b1;
`endif
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter W, default 28, counter/config width in bits (2..32).
REQ-003 SHALL have port clk input 1: system clock; all state on its rising edge.
REQ-004 SHALL have port rst input 1: asynchronous, active-high reset.
REQ-005 SHALL have port en input NCH: per-channel run enable.
REQ-006 SHALL have port period input NCH*W: per-channel terminal count P; output period is P+1 clk cycles.
REQ-007 SHALL have port high input NCH*W: per-channel high time H in clk cycles.
REQ-008 SHALL have port load input NCH: single-cycle strobe to capture period/high into the channel's pending register.
REQ-009 SHALL have port tick output NCH: one-cycle pulse per completed period.
REQ-010 SHALL have port out_clk output NCH: duty-shaped divided clock (fabric enable-style, not a clock-tree clock).
REQ-011 SHALL have port pend output NCH: pending configuration not yet applied.

Function
REQ-012 Each channel SHALL hold active registers P_act, H_act, a pending pair P_pnd, H_pnd, and a counter cnt of W bits.
REQ-013 While en[i]=1, cnt SHALL go 0,1,...,P_act, then wrap to 0; the wrap cycle is the cycle with cnt==P_act.
REQ-014 While en[i]=0, cnt SHALL be forced to 0 on the next edge, tick[i] and out_clk[i] SHALL be 0, and the count SHALL restart at 0 on re-enable.
REQ-015 tick[i] SHALL be registered: 1 for exactly one cycle, in the cycle after each wrap cycle with en[i]=1.
REQ-016 out_clk[i] SHALL be registered: next value = en[i] & (cnt_next < H_act), where cnt_next is the counter's next value.
REQ-017 H_act=0 SHALL give out_clk constantly 0; H_act>P_act SHALL give constantly 1 while enabled.
REQ-018 P_act=0 SHALL give tick every cycle while enabled.
REQ-019 load[i] SHALL capture period[i] and high[i] into the pending pair and set pend[i]=1 on the next edge; a later load before application SHALL overwrite it (last wins).
REQ-020 Pending values SHALL become active on a wrap-cycle edge, or on the next edge if en[i]=0; pend[i] SHALL clear on that same edge.
REQ-021 load coincident with a wrap cycle SHALL bypass the pending pair, become active for the period starting at cnt=0, and leave pend[i]=0.
REQ-022 A period SHALL never be truncated by reconfiguration; active values SHALL change only at a period boundary (glitch-free).
REQ-023 Channels SHALL be fully independent; arithmetic SHALL be unsigned W-bit, with no overflow because cnt never exceeds P_act.

Reset
REQ-024 rst SHALL asynchronously clear cnt, P_act, H_act, P_pnd, H_pnd, pend, tick, and out_clk to 0 in all channels.
REQ-025 rst asserted mid-period SHALL abort the period with no tick; after release, an enabled channel SHALL run with P_act=0 (tick every cycle, out_clk=0).

Configuration
REQ-026 Macro CLK_DIV_SYNC_EN, when defined, SHALL add port sync input 1.
REQ-027 With CLK_DIV_SYNC_EN defined, sync=1 SHALL force cnt of every channel to 0 on the next edge and apply pending values as at a wrap; no tick SHALL be produced by sync.
REQ-028 With CLK_DIV_SYNC_EN defined, sync SHALL take priority over a simultaneous wrap or load bypass (the load goes to pending).
REQ-029 Without CLK_DIV_SYNC_EN, the sync port and its logic SHALL be absent and channels SHALL free-run.

Structure
REQ-030 Package clk_div_pkg SHALL hold NCH_DEF=4, W_DEF=28, and a parametrisable chan_cfg_t struct {period, high}.
REQ-031 Per-channel logic SHALL be sub-module clk_div_chan, instantiated NCH times via generate; the top level SHALL only fan out ports and sync.

Verification
REQ-032 SHALL check: NCH=2, W=8, load P=3/H=2 with ch0 disabled, then en=1 -> pend clears next edge; tick every 4 cycles; out_clk 1,1,0,0 repeating.
REQ-033 SHALL check: P=9/H=5 running, load P=4/H=1 at cnt=2 -> current 10-cycle period completes unchanged; next periods are 5 cycles, 1 high.
REQ-034 SHALL check: load coincident with wrap cycle (P=3 -> P=1) -> next period is 2 cycles and pend never rises.
REQ-035 SHALL check: P=0, H=0 enabled -> tick=1 every cycle, out_clk=0; then H=5 -> out_clk=1 constantly.
REQ-036 SHALL check: rst pulsed at cnt=6 of P=9 -> all outputs 0 immediately; no tick for the aborted period; tick every cycle after release.
REQ-037 SHALL check, with CLK_DIV_SYNC_EN: ch0 P=3, ch1 P=5 free-running, sync pulse -> both cnt=0 next cycle; first ticks 4 and 6 cycles later respectively.
